// File: rtl/ref_price_sched_pkg.sv
// Shared types and default widths for the reference-price request scheduler.
package ref_price_sched_pkg;

   localparam int unsigned DEF_FP_WORD_SIZE = 64;
   localparam int unsigned DEF_DATA_WIDTH   = 32;
   localparam int unsigned DEF_N_REQ        = 4;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } sched_state_t;

endpackage

// File: rtl/ref_price_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating pointer.
module rr_arbiter
   import ref_price_sched_pkg::*;
#(
   parameter int unsigned N    = DEF_N_REQ,
   parameter int unsigned ID_W = $clog2(N)
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic [N-1:0]    i_req,
   output logic [N-1:0]    o_grant,
   output logic [ID_W-1:0] o_grant_id,
   output logic            o_grant_valid
);

   logic [ID_W-1:0] r_ptr;
   logic [ID_W-1:0] w_idx;

   always_comb begin
      o_grant       = '0;
      o_grant_id    = '0;
      o_grant_valid = 1'b0;
      w_idx         = '0;
      for (int unsigned k = 0; k < N; k++) begin
         w_idx = r_ptr + ID_W'(k);
         if (!o_grant_valid && i_req[w_idx]) begin
            o_grant_valid  = 1'b1;
            o_grant[w_idx] = 1'b1;
            o_grant_id     = w_idx;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_ptr <= '0;
      end else if (o_grant_valid) begin
         r_ptr <= o_grant_id + ID_W'(1);
      end
   end

endmodule

// File: rtl/ref_price_scheduler.sv
// Shares one ref_price core among N_REQ requesters: round-robin issue,
// in-order result tagging through a tag FIFO, and flush/drain control.
module ref_price_scheduler
   import ref_price_sched_pkg::*;
#(
   parameter int unsigned FP_WORD_SIZE = DEF_FP_WORD_SIZE,
   parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int unsigned N_REQ        = DEF_N_REQ,
   parameter int unsigned ID_W         = $clog2(N_REQ)
) (
   input  logic                                   i_clk,
   input  logic                                   i_reset,
   input  logic [N_REQ-1:0]                       i_req_valid,
   output logic [N_REQ-1:0]                       o_req_ready,
   input  logic [N_REQ-1:0][DATA_WIDTH-1:0]       i_req_curr_price,
   input  logic [N_REQ-1:0][DATA_WIDTH-1:0]       i_req_curr_time,
   input  logic [N_REQ-1:0][DATA_WIDTH-1:0]       i_req_terminal_time,
   input  logic [N_REQ-1:0][FP_WORD_SIZE-1:0]     i_req_inventory_state,
   input  logic [N_REQ-1:0][FP_WORD_SIZE-1:0]     i_req_volatility,
   input  logic [N_REQ-1:0][FP_WORD_SIZE-1:0]     i_req_risk_factor,
   output logic [DATA_WIDTH-1:0]                  o_core_curr_price,
   output logic [DATA_WIDTH-1:0]                  o_core_curr_time,
   output logic [DATA_WIDTH-1:0]                  o_core_terminal_time,
   output logic [FP_WORD_SIZE-1:0]                o_core_inventory_state,
   output logic [FP_WORD_SIZE-1:0]                o_core_volatility,
   output logic [FP_WORD_SIZE-1:0]                o_core_risk_factor,
   output logic                                   o_core_data_valid,
   input  logic [FP_WORD_SIZE-1:0]                i_core_ref_price,
   input  logic                                   i_core_data_valid,
   output logic [N_REQ-1:0][FP_WORD_SIZE-1:0]     o_res_ref_price,
   output logic [N_REQ-1:0]                       o_res_valid,
   input  logic [N_REQ-1:0]                       i_res_ready,
   input  logic                                   i_flush,
   output logic                                   o_idle,
   output logic                                   o_err
);

   sched_state_t r_state, w_state_nxt;

   logic [N_REQ-1:0]                   r_busy;
   logic [N_REQ-1:0]                   r_res_valid;
   logic [N_REQ-1:0][FP_WORD_SIZE-1:0] r_res_price;
   logic [N_REQ-1:0]                   w_elig;
   logic [N_REQ-1:0]                   w_grant;
   logic [N_REQ-1:0]                   w_res_done;
   logic [ID_W-1:0]                    w_win;
   logic                               w_accept;

   logic [ID_W-1:0] r_tag_mem [N_REQ];
   logic [ID_W-1:0] r_wr_ptr;
   logic [ID_W-1:0] r_rd_ptr;
   logic [ID_W:0]   r_count;
   logic [ID_W-1:0] w_tag;
   logic            w_pop;
   logic            w_orphan;
   logic            r_err;

   logic [DATA_WIDTH-1:0]   r_core_price;
   logic [DATA_WIDTH-1:0]   r_core_time;
   logic [DATA_WIDTH-1:0]   r_core_term;
   logic [FP_WORD_SIZE-1:0] r_core_inv;
   logic [FP_WORD_SIZE-1:0] r_core_vol;
   logic [FP_WORD_SIZE-1:0] r_core_risk;
   logic                    r_core_valid;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= RUN;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_elig      = '0;
      o_idle      = 1'b0;
      case (r_state)
         RUN: begin
            w_elig = i_req_valid & ~r_busy;
            if (i_flush) w_state_nxt = DRAIN;
         end
         DRAIN: begin
            if (r_count == '0) w_state_nxt = HALTED;
         end
         HALTED: begin
            o_idle = (r_count == '0);
            if (!i_flush) w_state_nxt = RUN;
         end
         default: w_state_nxt = RUN;
      endcase
   end

   rr_arbiter #(
      .N    (N_REQ),
      .ID_W (ID_W)
   ) u_arb (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_req         (w_elig),
      .o_grant       (w_grant),
      .o_grant_id    (w_win),
      .o_grant_valid (w_accept)
   );

   assign o_req_ready = w_grant;
   assign w_res_done  = r_res_valid & i_res_ready;

   // A core result with no tag outstanding cannot be routed; it is dropped and flagged.
   assign w_pop    = i_core_data_valid && (r_count != '0);
   assign w_orphan = i_core_data_valid && (r_count == '0);
   assign w_tag    = r_tag_mem[r_rd_ptr];

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int unsigned i = 0; i < N_REQ; i++) r_tag_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_err    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_tag_mem[r_wr_ptr] <= w_win;
            r_wr_ptr            <= r_wr_ptr + ID_W'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + ID_W'(1);
         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + (ID_W+1)'(1);
            2'b01:   r_count <= r_count - (ID_W+1)'(1);
            default: r_count <= r_count;
         endcase
         if (w_orphan) r_err <= 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_busy      <= '0;
         r_res_valid <= '0;
         r_res_price <= '0;
      end else begin
         r_busy <= (r_busy & ~w_res_done) | w_grant;
         for (int unsigned t = 0; t < N_REQ; t++) begin
            if (w_pop && (w_tag == ID_W'(t))) begin
               r_res_valid[t] <= 1'b1;
               r_res_price[t] <= i_core_ref_price;
            end else if (w_res_done[t]) begin
               r_res_valid[t] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_core_price <= '0;
         r_core_time  <= '0;
         r_core_term  <= '0;
         r_core_inv   <= '0;
         r_core_vol   <= '0;
         r_core_risk  <= '0;
         r_core_valid <= 1'b0;
      end else begin
         r_core_valid <= w_accept;
         if (w_accept) begin
            r_core_price <= i_req_curr_price[w_win];
            r_core_time  <= i_req_curr_time[w_win];
            r_core_term  <= i_req_terminal_time[w_win];
            r_core_inv   <= i_req_inventory_state[w_win];
            r_core_vol   <= i_req_volatility[w_win];
            r_core_risk  <= i_req_risk_factor[w_win];
         end
      end
   end

   assign o_core_curr_price      = r_core_price;
   assign o_core_curr_time       = r_core_time;
   assign o_core_terminal_time   = r_core_term;
   assign o_core_inventory_state = r_core_inv;
   assign o_core_volatility      = r_core_vol;
   assign o_core_risk_factor     = r_core_risk;
   assign o_core_data_valid      = r_core_valid;
   assign o_res_ref_price        = r_res_price;
   assign o_res_valid            = r_res_valid;
   assign o_err                  = r_err;

endmodule

// File: tb/tb_ref_price_scheduler.sv
// Directed bench for ref_price_scheduler; core modelled as result = price after 3 cycles.
module tb_ref_price_scheduler;

   localparam int unsigned N  = 4;
   localparam int unsigned DW = 32;
   localparam int unsigned FW = 64;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [N-1:0]            req_valid;
   logic [N-1:0]            req_ready;
   logic [N-1:0][DW-1:0]    req_price, req_time, req_term;
   logic [N-1:0][FW-1:0]    req_inv, req_vol, req_risk;
   logic [DW-1:0]           core_price, core_time, core_term;
   logic [FW-1:0]           core_inv, core_vol, core_risk;
   logic                    core_valid;
   logic [FW-1:0]           core_ref_price;
   logic                    core_ret_valid;
   logic [N-1:0][FW-1:0]    res_price;
   logic [N-1:0]            res_valid;
   logic [N-1:0]            res_ready;
   logic                    flush;
   logic                    idle;
   logic                    err;
   logic                    inject;

   int n_checks = 0;
   int n_err    = 0;

   logic [2:0]    pipe_v = '0;
   logic [FW-1:0] pipe_p [3] = '{default: '0};

   logic [3:0] exp_d [16] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                              4'b0000, 4'b0000, 4'b0001, 4'b0000,
                              4'b0100, 4'b1000, 4'b0000, 4'b0000,
                              4'b0001, 4'b0000, 4'b0100, 4'b1000};

   always #5 clk = ~clk;

   always @(posedge clk) begin
      pipe_v    <= {pipe_v[1:0], core_valid};
      pipe_p[0] <= {32'b0, core_price};
      pipe_p[1] <= pipe_p[0];
      pipe_p[2] <= pipe_p[1];
   end

   assign core_ret_valid = pipe_v[2] | inject;
   assign core_ref_price = pipe_p[2];

   ref_price_scheduler #(
      .FP_WORD_SIZE (FW),
      .DATA_WIDTH   (DW),
      .N_REQ        (N)
   ) dut (
      .i_clk                  (clk),
      .i_reset                (rst),
      .i_req_valid            (req_valid),
      .o_req_ready            (req_ready),
      .i_req_curr_price       (req_price),
      .i_req_curr_time        (req_time),
      .i_req_terminal_time    (req_term),
      .i_req_inventory_state  (req_inv),
      .i_req_volatility       (req_vol),
      .i_req_risk_factor      (req_risk),
      .o_core_curr_price      (core_price),
      .o_core_curr_time       (core_time),
      .o_core_terminal_time   (core_term),
      .o_core_inventory_state (core_inv),
      .o_core_volatility      (core_vol),
      .o_core_risk_factor     (core_risk),
      .o_core_data_valid      (core_valid),
      .i_core_ref_price       (core_ref_price),
      .i_core_data_valid      (core_ret_valid),
      .o_res_ref_price        (res_price),
      .o_res_valid            (res_valid),
      .i_res_ready            (res_ready),
      .i_flush                (flush),
      .o_idle                 (idle),
      .o_err                  (err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      res_ready = '1;
      flush     = 1'b0;
      inject    = 1'b0;
      for (int i = 0; i < N; i++) begin
         req_price[i] = DW'(100 + i);
         req_time[i]  = DW'(10 + i);
         req_term[i]  = DW'(20 + i);
         req_inv[i]   = FW'(64'h1000 + i);
         req_vol[i]   = FW'(64'h2000 + i);
         req_risk[i]  = FW'(64'h3000 + i);
      end
      repeat (3) tick();

      check("rst_ready", req_ready, 0);
      check("rst_core_valid", core_valid, 0);
      check("rst_core_price", core_price, 0);
      check("rst_core_inv", core_inv, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_err", err, 0);
      check("rst_idle", idle, 0);
      rst = 1'b0;

      // single requester, latency through core
      tick();
      req_valid = 4'b0001;
      #1;
      check("b_ready", req_ready, 4'b0001);
      tick();
      check("b_core_valid", core_valid, 1);
      check("b_core_price", core_price, 100);
      check("b_core_time", core_time, 10);
      check("b_core_term", core_term, 20);
      check("b_core_inv", core_inv, 64'h1000);
      check("b_core_vol", core_vol, 64'h2000);
      check("b_core_risk", core_risk, 64'h3000);
      check("b_busy_ready", req_ready, 0);
      req_valid = '0;
      tick();
      check("b_core_valid_off", core_valid, 0);
      check("b_core_hold", core_price, 100);
      tick();
      tick();
      check("b_res_early", res_valid, 0);
      tick();
      check("b_res_valid", res_valid, 4'b0001);
      check("b_res_price", res_price[0], 100);
      tick();
      check("b_res_clear", res_valid, 0);

      // all four from reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      req_valid = '1;
      #1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("c_grant%0d", i), req_ready, 64'(1) << i);
         tick();
         check($sformatf("c_core_valid%0d", i), core_valid, 1);
         check($sformatf("c_core_price%0d", i), core_price, 64'(100 + i));
      end
      check("c_no_grant", req_ready, 0);
      req_valid = '0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("c_res_valid%0d", i), res_valid, 64'(1) << i);
         check($sformatf("c_res_price%0d", i), res_price[i], 64'(100 + i));
      end
      tick();
      check("c_res_clear", res_valid, 0);

      // requester 1 result held back
      res_ready = 4'b1101;
      req_valid = '1;
      #1;
      for (int i = 0; i < 16; i++) begin
         check($sformatf("d_ready%0d", i), req_ready, exp_d[i]);
         if (i >= 6) check($sformatf("d_res1_held%0d", i), res_valid[1], 1);
         if (i < 15) tick();
      end
      check("d_res1_price", res_price[1], 101);
      req_valid = 4'b0010;
      res_ready = '1;
      tick();
      check("d_req1_regrant", req_ready, 4'b0010);
      tick();
      check("d_core_price1", core_price, 101);
      req_valid = '0;
      repeat (8) tick();
      check("d_drained", res_valid, 0);

      // flush with two in flight
      req_valid = 4'b0011;
      #1;
      check("e_grant0", req_ready, 4'b0001);
      tick();
      check("e_grant1", req_ready, 4'b0010);
      tick();
      req_valid = '0;
      flush     = 1'b1;
      tick();
      req_valid = '1;
      #1;
      for (int i = 3; i <= 7; i++) begin
         check($sformatf("e_no_grant%0d", i), req_ready, 0);
         if (i == 5) check("e_res0", res_valid, 4'b0001);
         if (i == 6) begin
            check("e_res1", res_valid, 4'b0010);
            check("e_idle_early", idle, 0);
         end
         if (i == 7) check("e_idle", idle, 1);
         if (i < 7) tick();
      end
      flush = 1'b0;
      tick();
      check("e_resume_grant", req_ready, 4'b0100);
      check("e_idle_off", idle, 0);
      tick();
      check("e_resume_core", core_valid, 1);
      check("e_resume_price", core_price, 102);
      check("e_next_grant", req_ready, 4'b1000);
      req_valid = '0;
      repeat (8) tick();

      // orphan core result
      check("f_err_pre", err, 0);
      inject = 1'b1;
      tick();
      inject = 1'b0;
      check("f_err_set", err, 1);
      check("f_dropped", res_valid, 0);
      repeat (3) tick();
      check("f_err_sticky", err, 1);

      // reset with three in flight
      req_valid = '1;
      #1;
      check("g_grant3", req_ready, 4'b1000);
      tick();
      check("g_grant0", req_ready, 4'b0001);
      tick();
      check("g_grant1", req_ready, 4'b0010);
      tick();
      rst       = 1'b1;
      req_valid = '0;
      #1;
      check("g_core_valid", core_valid, 0);
      check("g_core_price", core_price, 0);
      check("g_core_inv", core_inv, 0);
      check("g_res_valid", res_valid, 0);
      check("g_err", err, 0);
      check("g_idle", idle, 0);
      check("g_ready", req_ready, 0);
      for (int i = 0; i < 4; i++) check($sformatf("g_res_price%0d", i), res_price[i], 0);
      tick();
      rst       = 1'b0;
      req_valid = '1;
      #1;
      check("g_first_grant", req_ready, 4'b0001);
      req_valid = '0;
      tick();
      check("g_late_result_err", err, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
